swchrsp_fifo_sched: RTL and testbench
=====================================

// Module: swchrsp_fifo_sched
// PURPOSE
//  Packet-level round-robin scheduler draining NPORTS switch-response DMA FIFOs (MEMIF_SWCHRSP-backed)
//  into a single registered output stream. Sits between the per-port dma_fifo_exmem_swchrsp instances
//  and the downstream TX path. Owns every FIFO pull: grants one port and holds the grant until that
//  port's EOP word is transferred.
// PARAMETERS
//  NPORTS  4    number of requesting FIFOs (2..8)
//  DWIDTH  64   data word width; must match the FIFO DWIDTH
//  PW      $clog2(NPORTS)  port index width (derived, not overridden)
// PORTS
//  clks.clk     in   1               clock (AXI_clks.to_rtl interface)
//  clks.rst     in   1               async reset, active low
//  fifo_empty   in   NPORTS          per-port FIFO empty
//  fifo_data    in   NPORTS*DWIDTH   per-port FIFO data_out; port p = [p*DWIDTH +: DWIDTH]; valid while !empty
//  fifo_eop     in   NPORTS          per-port end-of-packet flag qualifying fifo_data
//  fifo_pull    out  NPORTS          per-port pull strobe; one-hot or zero
//  out_valid    out  1               output word valid
//  out_ready    in   1               downstream accept
//  out_data     out  DWIDTH          output word
//  out_eop      out  1               output word is last of packet
//  out_port     out  PW              source port of out_data
//  pkt_cnt      out  NPORTS*16       per-port completed-packet counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (clks.rst=0, async):
//   - state=IDLE; rr_last=NPORTS-1, so port 0 has top priority first.
//   - out_valid=0, out_data=0, out_eop=0, out_port=0, fifo_pull=0, pkt_cnt=0.
//  Output register:
//   - Single stage. can_load = !out_valid | out_ready.
//   - Loaded on the edge after a pull: data, eop, port. Pull-to-out_valid latency = 1 cycle.
//   - out_valid & !out_ready: out_data/out_eop/out_port held stable, no pull issued.
//  FSM:
//   - IDLE:
//     - Combinational RR search over !fifo_empty, from rr_last+1 wrapping modulo NPORTS.
//     - If a port p is found and can_load: fifo_pull[p]=1 that same cycle; rr_last<=p.
//     - Next state: LOCK if the pulled word has fifo_eop[p]=0; stay IDLE if fifo_eop[p]=1
//       (single-word packet).
//   - LOCK (grant=rr_last):
//     - fifo_pull[grant] = can_load & !fifo_empty[grant].
//     - Granted FIFO empty mid-packet: stall. Grant is kept; no other port is served.
//     - Pull with fifo_eop[grant]=1: go to IDLE.
//  Timing and arbitration rules:
//   - One pull-side idle cycle is never inserted; the IDLE arbitration and pull share a cycle.
//     Result: back-to-back packets stream at full rate.
//   - Fairness: after a packet from p, p has the lowest priority on the next arbitration.
//   - fifo_pull is never asserted for a port whose fifo_empty=1; this is asserted (SVA).
//   - Words from two ports never interleave between an out_eop boundary.
//  Reset mid-packet:
//   - Everything returns to reset values. The partial packet is left in the FIFO; upstream
//     resets the FIFOs with the same clks.rst.
// CONFIGURATION
//  SWCHRSP_SCHED_PKTCNT_EN
//   - Defined: pkt_cnt[p*16 +: 16] increments on each output transfer (out_valid & out_ready
//     & out_eop) with out_port=p. Wraps 16'hFFFF->0. Cleared only by reset.
//   - Undefined: pkt_cnt tied to 0 and no counter flops are built.
// TESTING
//  1. Ports 0,2 each hold a 3-word packet (eop on word 3); out_ready=1.
//     -> words P0w0..w2, then P2w0..w2, with no gap and out_port 0,0,0,2,2,2.
//  2. All 4 ports hold 1-word packets, twice each.
//     -> out_port sequence 0,1,2,3,0,1,2,3.
//  3. Port 1 packet of 4 words, FIFO empties after word 2 for 5 cycles while port 3 is non-empty.
//     -> fifo_pull[3] stays 0; resumes P1w2, w3, then serves port 3.
//  4. out_ready=0 for 6 cycles mid-packet with data 64'hDEAD_BEEF_0000_0001 on output.
//     -> out_data stable, fifo_pull=0 throughout, no word lost or duplicated.
//  5. Reset asserted while in LOCK on port 2 after 1 of 3 words.
//     -> out_valid=0 and fifo_pull=0 immediately; after release, port 0 wins first if non-empty.
//  6. SWCHRSP_SCHED_PKTCNT_EN defined: 3 packets from port 1, 1 from port 0.
//     -> pkt_cnt port1=3, port0=1, others 0. Undefined: all 0.

Source files
------------

// File: rtl/swchrsp_fifo_sched.sv
// ----------------------------------------------------------------------------
// swchrsp_fifo_sched
//
// Packet-level round-robin scheduler that drains NPORTS switch-response DMA
// FIFOs into one registered output stream. The scheduler owns every FIFO
// pull. It grants one port and keeps that grant until the port's EOP word has
// been pulled, so words from different packets never interleave.
//
// Optional feature macro: SWCHRSP_SCHED_PKTCNT_EN
//   defined   : per-port 16-bit completed-packet counters on pkt_cnt_o
//   undefined : pkt_cnt_o is tied to zero and no counter flops exist
//
// Parameters
//   NPORTS  number of requesting FIFOs (2..8)
//   DWIDTH  data word width, matches the FIFO width
//   PW      port index width, derived from NPORTS
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous reset, active low
//   fifo_empty_i  per-port FIFO empty
//   fifo_data_i   per-port FIFO head word, port p at [p*DWIDTH +: DWIDTH]
//   fifo_eop_i    per-port end-of-packet flag for the head word
//   fifo_pull_o   per-port pull strobe, one-hot or zero
//   out_valid_o   output word valid
//   out_ready_i   downstream accept
//   out_data_o    output word
//   out_eop_o     output word is the last of its packet
//   out_port_o    source port of out_data_o
//   pkt_cnt_o     per-port completed-packet counters, port p at [p*16 +: 16]
//   state_o       debug view of the scheduler FSM (0 = IDLE, 1 = LOCK)
//
// Handshake: a word moves downstream on a rising edge where out_valid_o and
// out_ready_i are both high. While out_valid_o is high and out_ready_i is low
// the output word, eop and port are held stable and no FIFO is pulled. A FIFO
// word moves on a rising edge where fifo_pull_o[p] is high; fifo_pull_o[p] is
// only raised while fifo_empty_i[p] is low.
// ----------------------------------------------------------------------------
module swchrsp_fifo_sched #(
    parameter  int NPORTS = 4,
    parameter  int DWIDTH = 64,
    localparam int PW     = $clog2(NPORTS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NPORTS-1:0]        fifo_empty_i,
    input  logic [NPORTS*DWIDTH-1:0] fifo_data_i,
    input  logic [NPORTS-1:0]        fifo_eop_i,
    output logic [NPORTS-1:0]        fifo_pull_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DWIDTH-1:0]        out_data_o,
    output logic                     out_eop_o,
    output logic [PW-1:0]            out_port_o,
    output logic [NPORTS*16-1:0]     pkt_cnt_o,
    output logic                     state_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       rr_last_q, rr_last_d;

    logic                out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]   out_data_q, out_data_d;
    logic                out_eop_q, out_eop_d;
    logic [PW-1:0]       out_port_q, out_port_d;

    logic                can_load;
    logic                rr_found;
    logic [PW-1:0]       rr_pick;
    logic [PW-1:0]       rr_cand;

    logic                pull_en;
    logic [PW-1:0]       pull_idx;
    logic [DWIDTH-1:0]   pull_data;
    logic                pull_eop;

    // The output register can take a new word when it is empty or when its
    // current word leaves on this edge.
    assign can_load = !out_valid_q || out_ready_i;

    // ------------------------------------------------------------------------
    // Round-robin search over non-empty ports, starting just after the port
    // that was granted last. Iterating from the farthest offset down to the
    // nearest lets the nearest candidate overwrite the others, so the result
    // is the first non-empty port in priority order.
    // ------------------------------------------------------------------------
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_last_q;
        rr_cand  = '0;
        for (int i = NPORTS; i >= 1; i--) begin
            rr_cand = PW'((int'(rr_last_q) + i) % NPORTS);
            if (!fifo_empty_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scheduler FSM, next-state and pull decision.
    // IDLE arbitrates and pulls in the same cycle, so back-to-back packets
    // stream without a bubble. LOCK keeps pulling the granted port until its
    // EOP word; an empty granted FIFO simply stalls, no other port is served.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        pull_en   = 1'b0;
        pull_idx  = rr_last_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_found && can_load) begin
                    pull_en   = 1'b1;
                    pull_idx  = rr_pick;
                    rr_last_d = rr_pick;
                    // A single-word packet completes here; stay in IDLE.
                    if (!fifo_eop_i[rr_pick]) begin
                        state_d = ST_LOCK;
                    end
                end
            end

            ST_LOCK: begin
                if (can_load && !fifo_empty_i[rr_last_q]) begin
                    pull_en = 1'b1;
                    if (fifo_eop_i[rr_last_q]) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word being pulled this cycle (only meaningful when pull_en is high).
    always_comb begin
        pull_data = fifo_data_i[int'(pull_idx)*DWIDTH +: DWIDTH];
        pull_eop  = fifo_eop_i[pull_idx];
    end

    // Pull strobe. Gated with reset so no FIFO is popped while the scheduler
    // is held in reset, even though the IDLE search is combinational.
    always_comb begin
        fifo_pull_o = '0;
        if (pull_en && rst_ni) begin
            fifo_pull_o[pull_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output register next-state. A pull always loads; otherwise an accepted
    // word empties the register. Data, eop and port hold their last value
    // when the register is empty.
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eop_d   = out_eop_q;
        out_port_d  = out_port_q;
        if (pull_en) begin
            out_valid_d = 1'b1;
            out_data_d  = pull_data;
            out_eop_d   = pull_eop;
            out_port_d  = pull_idx;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. rr_last resets to the highest port so port 0 is the
    // first candidate after reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= PW'(NPORTS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eop_q   <= 1'b0;
            out_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_eop_q   <= out_eop_d;
            out_port_q  <= out_port_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_eop_o   = out_eop_q;
    assign out_port_o  = out_port_q;
    assign state_o     = state_q;

    // ------------------------------------------------------------------------
    // Completed-packet counters: a packet completes when its EOP word is
    // accepted downstream. Counters wrap at 16 bits.
    // ------------------------------------------------------------------------
`ifdef SWCHRSP_SCHED_PKTCNT_EN
    for (genvar p = 0; p < NPORTS; p++) begin : g_pkt_cnt
        logic [15:0] cnt_q, cnt_d;
        logic        done;

        assign done = out_valid_q && out_ready_i && out_eop_q &&
                      (out_port_q == PW'(p));

        always_comb begin
            cnt_d = cnt_q;
            if (done) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign pkt_cnt_o[p*16 +: 16] = cnt_q;
    end
`else
    assign pkt_cnt_o = '0;
`endif

    // ------------------------------------------------------------------------
    // Pull safety properties.
    // ------------------------------------------------------------------------
    a_pull_not_empty : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ((fifo_pull_o & fifo_empty_i) == '0)
    );

    a_pull_onehot0 : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        $onehot0(fifo_pull_o)
    );

endmodule

// File: tb/tb_swchrsp_fifo_sched.sv
// ----------------------------------------------------------------------------
// tb_swchrsp_fifo_sched
//
// Bench for swchrsp_fifo_sched (NPORTS=4, DWIDTH=64). The bench owns simple
// per-port FIFO stubs (circular buffers) that feed the scheduler, and a
// packet-level reference: which port may be served next, which word must come
// out, and how many packets each port has completed.
// ----------------------------------------------------------------------------
module tb_swchrsp_fifo_sched;

    localparam int NP    = 4;
    localparam int DW    = 64;
    localparam int PW    = 2;
    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NP-1:0]     fifo_empty_i;
    logic [NP*DW-1:0]  fifo_data_i;
    logic [NP-1:0]     fifo_eop_i;
    logic [NP-1:0]     fifo_pull_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DW-1:0]     out_data_o;
    logic              out_eop_o;
    logic [PW-1:0]     out_port_o;
    logic [NP*16-1:0]  pkt_cnt_o;
    logic              state_o;

    swchrsp_fifo_sched #(.NPORTS(NP), .DWIDTH(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_eop_i   (fifo_eop_i),
        .fifo_pull_o  (fifo_pull_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_eop_o    (out_eop_o),
        .out_port_o   (out_port_o),
        .pkt_cnt_o    (pkt_cnt_o),
        .state_o      (state_o)
    );

    // ---------------- counters ----------------
    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- FIFO stubs ----------------
    logic [DW-1:0] fq_data [NP][DEPTH];
    logic          fq_eop  [NP][DEPTH];
    int            fq_head [NP];
    int            fq_tail [NP];

    function automatic int fq_cnt(input int p);
        return fq_tail[p] - fq_head[p];
    endfunction

    task automatic push_word(input int p, input logic [DW-1:0] d, input logic e);
        fq_data[p][fq_tail[p] % DEPTH] = d;
        fq_eop[p][fq_tail[p] % DEPTH]  = e;
        fq_tail[p]++;
    endtask

    task automatic push_pkt(input int p, input int len, input int tag);
        for (int i = 0; i < len; i++) begin
            push_word(p, {8'(p), 24'(tag), 32'(i)}, (i == len - 1));
        end
    endtask

    task automatic drive_fifo();
        for (int p = 0; p < NP; p++) begin
            fifo_empty_i[p]          = (fq_cnt(p) == 0);
            fifo_data_i[p*DW +: DW]  = fq_data[p][fq_head[p] % DEPTH];
            fifo_eop_i[p]            = fq_eop[p][fq_head[p] % DEPTH];
        end
    endtask

    // ---------------- reference model ----------------
    // m_valid/m_data/...: the word that must currently sit on the output.
    // m_locked: a packet from m_last is partly delivered.
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_eop;
    int            m_port;
    logic          m_locked;
    int            m_last;
    int            m_cnt [NP];
    int            exp_pick;

    int            log_port [$];
    logic [DW-1:0] log_data [$];
    int            log_cyc  [$];

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_eop    = 1'b0;
        m_port   = 0;
        m_locked = 1'b0;
        m_last   = NP - 1;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    endtask

    // Port that must be pulled this cycle, or -1.
    function automatic int model_pick();
        if (!rst_n) return -1;
        if (m_valid && !out_ready_i) return -1;
        if (m_locked) return (fq_cnt(m_last) > 0) ? m_last : -1;
        for (int k = 1; k <= NP; k++) begin
            if (fq_cnt((m_last + k) % NP) > 0) return (m_last + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [NP*16-1:0] exp_cnt_vec();
        logic [NP*16-1:0] v;
        v = '0;
`ifdef SWCHRSP_SCHED_PKTCNT_EN
        for (int p = 0; p < NP; p++) v[p*16 +: 16] = 16'(m_cnt[p]);
`endif
        return v;
    endfunction

    task automatic model_update(input int pk);
        int h;
        if (m_valid && out_ready_i) begin
            log_port.push_back(m_port);
            log_data.push_back(m_data);
            log_cyc.push_back(cyc);
            if (m_eop) m_cnt[m_port] = (m_cnt[m_port] + 1) % 65536;
            m_valid = 1'b0;
        end
        if (pk >= 0) begin
            h        = fq_head[pk] % DEPTH;
            m_data   = fq_data[pk][h];
            m_eop    = fq_eop[pk][h];
            fq_head[pk]++;
            m_valid  = 1'b1;
            m_port   = pk;
            m_last   = pk;
            m_locked = !m_eop;
        end
    endtask

    // One clock: compare on the falling edge, advance model after the rise.
    task automatic step();
        logic [NP-1:0] ev;
        @(negedge clk);
        exp_pick = model_pick();
        ev = '0;
        if (exp_pick >= 0) ev[exp_pick] = 1'b1;
        chk("fifo_pull", fifo_pull_o, ev);
        chk("out_valid", out_valid_o, m_valid);
        if (m_valid) begin
            chk("out_data", out_data_o, m_data);
            chk("out_eop", out_eop_o, m_eop);
            chk("out_port", out_port_o, m_port);
        end
        chk("pkt_cnt", pkt_cnt_o, exp_cnt_vec());
        @(posedge clk);
        #1;
        if (rst_n) model_update(exp_pick);
        cyc++;
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready_i = 1'b0;
        #1;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        log_port.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic check_ports(input string name, input int exp[$]);
        int act;
        chk({name, "_len"}, log_port.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < log_port.size()) ? log_port[i] : 99;
            chk($sformatf("%s_port%0d", name, i), act, exp[i]);
        end
    endtask

    // ---------------- random packet generator ----------------
    int gen_left [NP];
    int gen_seq = 0;

    task automatic gen_random(input logic allow_new);
        for (int p = 0; p < NP; p++) begin
            if (fq_cnt(p) < DEPTH - 8 && $urandom_range(0, 9) < 3) begin
                if (gen_left[p] == 0 && allow_new) gen_left[p] = $urandom_range(1, 4);
                if (gen_left[p] > 0) begin
                    push_word(p, {8'(p), 24'(gen_seq), 32'($urandom)}, (gen_left[p] == 1));
                    gen_left[p]--;
                    gen_seq++;
                end
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e[$];
        logic found;
        logic done;

        rst_n       = 1'b0;
        out_ready_i = 1'b0;
        for (int p = 0; p < NP; p++) begin
            fq_head[p]  = 0;
            fq_tail[p]  = 0;
            gen_left[p] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                fq_data[p][i] = '0;
                fq_eop[p][i]  = 1'b0;
            end
        end
        drive_fifo();
        model_reset();

        // Reset values
        step();
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_out_data", out_data_o, 64'd0);
        chk("rst_out_eop", out_eop_o, 1'b0);
        chk("rst_out_port", out_port_o, 2'd0);
        chk("rst_fifo_pull", fifo_pull_o, 4'd0);
        chk("rst_pkt_cnt", pkt_cnt_o, 64'd0);
        step();
        rst_n = 1'b1;

        // 1: two 3-word packets on ports 0 and 2, streamed without a gap
        clear_log();
        push_pkt(0, 3, 1);
        push_pkt(2, 3, 2);
        out_ready_i = 1'b1;
        drive_fifo();
        repeat (10) step();
        e = '{0, 0, 0, 2, 2, 2};
        check_ports("t1", e);
        if (log_cyc.size() >= 6) chk("t1_nogap", log_cyc[5] - log_cyc[0], 5);

        // 2: four ports, two single-word packets each
        do_reset();
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) push_pkt(p, 1, 10 + r);
        out_ready_i = 1'b1;
        drive_fifo();
        repeat (12) step();
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_ports("t2", e);

        // 3: port 1 runs dry mid-packet while port 3 waits
        clear_log();
        push_word(1, 64'h1100, 1'b0);
        push_word(1, 64'h1101, 1'b0);
        push_pkt(3, 2, 30);
        out_ready_i = 1'b1;
        drive_fifo();
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_no_p3_pull", fifo_pull_o[3], 1'b0);
            chk("t3_stall_pull", fifo_pull_o, 4'd0);
        end
        push_word(1, 64'h1102, 1'b0);
        push_word(1, 64'h1103, 1'b1);
        drive_fifo();
        repeat (8) step();
        e = '{1, 1, 1, 1, 3, 3};
        check_ports("t3", e);
        if (log_data.size() >= 4) chk("t3_p1w3", log_data[3], 64'h1103);

        // 4: downstream backpressure with a known word on the output
        clear_log();
        push_word(0, 64'h1000, 1'b0);
        push_word(0, 64'hDEAD_BEEF_0000_0001, 1'b0);
        push_word(0, 64'h1002, 1'b1);
        out_ready_i = 1'b1;
        drive_fifo();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (m_valid && m_data == 64'hDEAD_BEEF_0000_0001) found = 1'b1;
        end
        chk("t4_reach", found, 1'b1);
        out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_hold_data", out_data_o, 64'hDEAD_BEEF_0000_0001);
            chk("t4_hold_valid", out_valid_o, 1'b1);
            chk("t4_no_pull", fifo_pull_o, 4'd0);
        end
        out_ready_i = 1'b1;
        repeat (6) step();
        chk("t4_len", log_data.size(), 3);
        if (log_data.size() >= 3) begin
            chk("t4_w0", log_data[0], 64'h1000);
            chk("t4_w1", log_data[1], 64'hDEAD_BEEF_0000_0001);
            chk("t4_w2", log_data[2], 64'h1002);
        end

        // 5: reset while locked on port 2 after its first word
        push_pkt(2, 3, 50);
        out_ready_i = 1'b1;
        drive_fifo();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (m_locked && m_last == 2) found = 1'b1;
        end
        chk("t5_reach", found, 1'b1);
        push_pkt(0, 1, 51);
        drive_fifo();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid_o, 1'b0);
        chk("t5_rst_pull", fifo_pull_o, 4'd0);
        chk("t5_rst_data", out_data_o, 64'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        clear_log();
        repeat (10) step();
        e = '{0, 2, 2};
        check_ports("t5", e);

        // 6: packet counters, 3 packets from port 1 and 1 from port 0
        do_reset();
        push_pkt(1, 2, 60);
        push_pkt(1, 1, 61);
        push_pkt(1, 3, 62);
        push_pkt(0, 2, 63);
        out_ready_i = 1'b1;
        drive_fifo();
        repeat (20) step();
`ifdef SWCHRSP_SCHED_PKTCNT_EN
        chk("t6_pkt_cnt", pkt_cnt_o, {16'd0, 16'd0, 16'd3, 16'd1});
`else
        chk("t6_pkt_cnt", pkt_cnt_o, 64'd0);
`endif

        // Random traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            gen_random(1'b1);
            out_ready_i = ($urandom_range(0, 3) != 0);
            drive_fifo();
            step();
        end
        out_ready_i = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            done = !m_valid && !m_locked;
            for (int p = 0; p < NP; p++)
                if (fq_cnt(p) != 0 || gen_left[p] != 0) done = 1'b0;
            if (!done) begin
                gen_random(1'b0);
                drive_fifo();
                step();
            end
        end
        chk("drain_done", done, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
